// File: rtl/buffered_char_reader.sv
// rtl/buffered_char_reader.sv - loadable character buffer streamed one char per cycle from an offset
// Optional wrap-around streaming is enabled with `define BUFFERED_READER_LOOP_EN (adds the loop input).
module buffered_char_reader #(
  parameter int CHAR_WIDTH = 8,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int ARG_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  state_enable,
  input  logic [ARG_WIDTH-1:0]  argument,
  input  logic                  pause,
`ifdef BUFFERED_READER_LOOP_EN
  input  logic                  loop,
`endif
  input  logic                  load_we,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [CHAR_WIDTH-1:0] load_data,
  output logic [CHAR_WIDTH-1:0] char,
  output logic                  char_valid,
  output logic                  has_finished,
  output logic [ADDR_WIDTH:0]   char_index
);

  localparam int IW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CHAR_WIDTH-1:0] char_q, char_d;
  logic                  valid_q, valid_d;
  logic                  fin_q, fin_d;
  logic [IW-1:0]         idx_q, idx_d;

  logic [CHAR_WIDTH-1:0] mem [DEPTH];
  logic [CHAR_WIDTH-1:0] rd_char;
  logic                  at_end;
  logic                  terminate;
  logic                  arg_out_of_range;

`ifdef BUFFERED_READER_LOOP_EN
  logic [IW-1:0]         start_q, start_d;
`endif

  // Buffer is only writable while the reader is parked in IDLE.
  always_ff @(posedge clock) begin
    if (load_we && state_q == IDLE) begin
      mem[load_addr] <= load_data;
    end
  end

  assign rd_char          = mem[idx_q[ADDR_WIDTH-1:0]];
  // DEPTH is a power of two, so the index MSB marks "past the last entry".
  assign at_end           = idx_q[ADDR_WIDTH];
  assign terminate        = at_end || (rd_char == '0);
  assign arg_out_of_range = (argument >= ARG_WIDTH'(DEPTH));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      char_q  <= '0;
      valid_q <= 1'b0;
      fin_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      char_q  <= char_d;
      valid_q <= valid_d;
      fin_q   <= fin_d;
      idx_q   <= idx_d;
    end
  end

`ifdef BUFFERED_READER_LOOP_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      start_q <= '0;
    end else begin
      start_q <= start_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    char_d  = char_q;
    valid_d = 1'b0;
    fin_d   = fin_q;
    idx_d   = idx_q;
`ifdef BUFFERED_READER_LOOP_EN
    start_d = start_q;
`endif

    if (!state_enable) begin
      state_d = IDLE;
      char_d  = '0;
      fin_d   = 1'b0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          idx_d = argument[IW-1:0];
`ifdef BUFFERED_READER_LOOP_EN
          start_d = argument[IW-1:0];
`endif
          if (arg_out_of_range) begin
            state_d = DONE;
            fin_d   = 1'b1;
          end else begin
            state_d = STREAM;
          end
        end

        STREAM: begin
          // Pause outranks the terminator; it is re-examined on the first free edge.
          if (!pause) begin
            if (terminate) begin
`ifdef BUFFERED_READER_LOOP_EN
              if (loop) begin
                idx_d = start_q;
              end else begin
                state_d = DONE;
                fin_d   = 1'b1;
              end
`else
              state_d = DONE;
              fin_d   = 1'b1;
`endif
            end else begin
              char_d  = rd_char;
              valid_d = 1'b1;
              idx_d   = idx_q + IW'(1);
            end
          end
        end

        DONE: begin
          fin_d = 1'b1;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign char         = char_q;
  assign char_valid   = valid_q;
  assign has_finished = fin_q;
  assign char_index   = idx_q;

endmodule

// File: tb/tb_buffered_char_reader.sv
// tb/tb_buffered_char_reader.sv - table, random and directed checks for buffered_char_reader
module tb_buffered_char_reader;
  localparam int CW    = 8;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int ARGW  = 8;

  localparam int C_LT = 60;
  localparam int C_GT = 62;
  localparam int C_H  = 104;
  localparam int C_P  = 112;
  localparam int C_A  = 97;
  localparam int C_B  = 98;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          state_enable = 1'b0;
  logic [ARGW-1:0] argument = '0;
  logic          pause = 1'b0;
  logic          load_we = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [CW-1:0] load_data = '0;
  logic [CW-1:0] char;
  logic          char_valid;
  logic          has_finished;
  logic [AW:0]   char_index;
`ifdef BUFFERED_READER_LOOP_EN
  logic          loop = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [CW-1:0] mem_model [DEPTH];
  logic [CW-1:0] exp_q [$];

  typedef struct {
    int kind;
    int arg;
    int pause_pct;
    int exp_len;
    int exp_first;
    int exp_last;
  } vec_t;

  vec_t vecs [9];

  always #5 clock = ~clock;

  buffered_char_reader #(
    .CHAR_WIDTH(CW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .ARG_WIDTH(ARGW)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .state_enable (state_enable),
    .argument     (argument),
    .pause        (pause),
`ifdef BUFFERED_READER_LOOP_EN
    .loop         (loop),
`endif
    .load_we      (load_we),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .char         (char),
    .char_valid   (char_valid),
    .has_finished (has_finished),
    .char_index   (char_index)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill(input int kind);
    string s;
    s = "<p>hi</p>";
    for (int i = 0; i < DEPTH; i++) begin
      case (kind)
        0: mem_model[i] = (i < s.len()) ? s[i] : 8'h00;
        1: mem_model[i] = 8'(C_A);
        3: mem_model[i] = (i == 0) ? 8'(C_A) : (i == 1) ? 8'(C_B) : 8'h00;
        default: mem_model[i] = ($urandom_range(0, 99) < 6) ? 8'h00 : 8'($urandom_range(1, 255));
      endcase
    end
  endtask

  task automatic load_buf();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      load_we   = 1'b1;
      load_addr = AW'(i);
      load_data = mem_model[i];
    end
    @(negedge clock);
    load_we = 1'b0;
  endtask

  task automatic run_stream(input int arg, input int pause_pct, input int exp_len,
                            input int exp_first, input int exp_last);
    int k;
    int first_c;
    int fin_c;
    bit prev_pause;
    logic [CW-1:0] first_ch;
    logic [CW-1:0] last_ch;
    logic [CW-1:0] hold_ch;

    exp_q.delete();
    for (int i = arg; i < DEPTH; i++) begin
      if (mem_model[i] == 8'h00) break;
      exp_q.push_back(mem_model[i]);
    end

    @(negedge clock);
    argument     = ARGW'(arg);
    state_enable = 1'b1;
    pause        = 1'b0;
    prev_pause   = 1'b0;
    k = 0; first_c = -1; fin_c = -1;
    first_ch = '0; last_ch = '0;

    for (int c = 0; c < 400 && fin_c < 0; c++) begin
      @(negedge clock);
      chk("no_valid_after_paused_edge", 32'(char_valid & prev_pause), 0);
      if (char_valid) begin
        if (k < exp_q.size()) chk("stream_char", 32'(char), 32'(exp_q[k]));
        else                  chk("extra_char", 32'(char_valid), 0);
        if (k == 0) begin
          first_ch = char;
          first_c  = c;
        end
        last_ch = char;
        k++;
      end
      if (arg < DEPTH) chk("char_index", 32'(char_index), 32'(arg + k));
      if (has_finished) fin_c = c;
      prev_pause = ($urandom_range(0, 99) < pause_pct);
      pause      = prev_pause;
    end

    chk("finished_reached", 32'(fin_c >= 0), 1);
    chk("char_count", 32'(k), 32'(exp_q.size()));
    if (exp_len >= 0) chk("char_count_table", 32'(k), 32'(exp_len));
    if (exp_len > 0) begin
      chk("first_char", 32'(first_ch), 32'(exp_first));
      chk("last_char", 32'(last_ch), 32'(exp_last));
    end
    if (pause_pct == 0) begin
      if (exp_q.size() > 0) chk("first_latency", 32'(first_c), 1);
      chk("finish_cycle", 32'(fin_c), (arg >= DEPTH) ? 32'd0 : 32'(exp_q.size() + 1));
    end

    hold_ch = (exp_q.size() > 0) ? exp_q[exp_q.size() - 1] : 8'h00;
    repeat (3) begin
      @(negedge clock);
      chk("done_finished", 32'(has_finished), 1);
      chk("done_valid", 32'(char_valid), 0);
      chk("done_char_hold", 32'(char), 32'(hold_ch));
      pause = 1'($urandom_range(0, 1));
    end

    state_enable = 1'b0;
    pause        = 1'b0;
    @(negedge clock);
    chk("disable_char", 32'(char), 0);
    chk("disable_valid", 32'(char_valid), 0);
    chk("disable_finished", 32'(has_finished), 0);
    chk("disable_index", 32'(char_index), 0);
  endtask

  task automatic wait_valids(input int want, input string name);
    int n;
    n = 0;
    for (int c = 0; c < 40 && n < want; c++) begin
      @(negedge clock);
      if (char_valid) n++;
    end
    chk(name, 32'(n), 32'(want));
  endtask

  initial begin
    vecs[0] = '{0, 0,   0,  9,  C_LT, C_GT};
    vecs[1] = '{0, 3,   0,  6,  C_H,  C_GT};
    vecs[2] = '{0, 8,   0,  1,  C_GT, C_GT};
    vecs[3] = '{0, 9,   0,  0,  0,    0};
    vecs[4] = '{1, 0,   0,  64, C_A,  C_A};
    vecs[5] = '{1, 63,  0,  1,  C_A,  C_A};
    vecs[6] = '{1, 64,  0,  0,  0,    0};
    vecs[7] = '{1, 200, 0,  0,  0,    0};
    vecs[8] = '{0, 0,   40, 9,  C_LT, C_GT};

    #12;
    chk("reset_char", 32'(char), 0);
    chk("reset_valid", 32'(char_valid), 0);
    chk("reset_finished", 32'(has_finished), 0);
    chk("reset_index", 32'(char_index), 0);
    @(negedge clock);
    resetn = 1'b1;

    foreach (vecs[i]) begin
      fill(vecs[i].kind);
      load_buf();
      run_stream(vecs[i].arg, vecs[i].pause_pct, vecs[i].exp_len,
                 vecs[i].exp_first, vecs[i].exp_last);
    end

    for (int r = 0; r < 12; r++) begin
      fill(2);
      load_buf();
      run_stream(int'($urandom_range(0, 70)), int'($urandom_range(0, 50)), -1, 0, 0);
    end

    // Pause after the second character freezes char and index.
    fill(0);
    load_buf();
    @(negedge clock);
    argument = '0; state_enable = 1'b1; pause = 1'b0;
    wait_valids(2, "pause_setup");
    pause = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("pause_char", 32'(char), C_P);
      chk("pause_valid", 32'(char_valid), 0);
      chk("pause_index", 32'(char_index), 2);
    end
    pause = 1'b0;
    @(negedge clock);
    chk("resume_char", 32'(char), C_GT);
    chk("resume_valid", 32'(char_valid), 1);
    chk("resume_index", 32'(char_index), 3);
    state_enable = 1'b0;
    @(negedge clock);

    // Mid-stream abort; a write attempted while streaming must be dropped.
    argument = '0; state_enable = 1'b1;
    wait_valids(4, "abort_setup");
    load_we = 1'b1; load_addr = AW'(5); load_data = 8'h5A;
    @(negedge clock);
    load_we = 1'b0; state_enable = 1'b0;
    @(negedge clock);
    chk("abort_char", 32'(char), 0);
    chk("abort_valid", 32'(char_valid), 0);
    chk("abort_finished", 32'(has_finished), 0);
    chk("abort_index", 32'(char_index), 0);
    argument = 8'd5; state_enable = 1'b1;
    @(negedge clock);
    chk("restart_no_char_on_enable", 32'(char_valid), 0);
    @(negedge clock);
    chk("restart_char", 32'(char), C_LT);
    chk("restart_valid", 32'(char_valid), 1);

    // Asynchronous reset between clock edges.
    @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    chk("async_reset_char", 32'(char), 0);
    chk("async_reset_valid", 32'(char_valid), 0);
    chk("async_reset_index", 32'(char_index), 0);
    @(negedge clock);
    state_enable = 1'b0;
    resetn = 1'b1;
    @(negedge clock);

`ifdef BUFFERED_READER_LOOP_EN
    fill(3);
    load_buf();
    begin
      int n;
      int fin_seen;
      loop = 1'b1; argument = '0; state_enable = 1'b1;
      n = 0;
      for (int c = 0; c < 60 && n < 10; c++) begin
        @(negedge clock);
        chk("loop_no_finish", 32'(has_finished), 0);
        if (char_valid) begin
          chk("loop_char", 32'(char), (n % 2 == 0) ? C_A : C_B);
          n++;
        end
      end
      chk("loop_count", 32'(n), 10);
      loop = 1'b0;
      fin_seen = 0;
      for (int c = 0; c < 10 && fin_seen == 0; c++) begin
        @(negedge clock);
        if (has_finished) fin_seen = 1;
      end
      chk("loop_off_finishes", 32'(fin_seen), 1);
      state_enable = 1'b0;
      @(negedge clock);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/buffered_char_reader.md
Name: buffered_char_reader

Overview:
Parametrised character-stream source for the reading stage. It holds a loadable character buffer and streams it one character per cycle to the parser, starting at an offset given by `argument`. The stream stops at a NUL terminator or at the buffer end. It keeps the `state_enable` / `pause` / `has_finished` contract of the hard-coded test reader, so it drops into the same state-machine slot, but serves arbitrary documents.

Parameters:
- CHAR_WIDTH, 8, bits per character (matches the `CHAR_BITES` width).
- DEPTH, 64, buffer entries (power of two, ≥2).
- ADDR_WIDTH, 6, log2(DEPTH).
- ARG_WIDTH, 8, width of `argument` (≥ ADDR_WIDTH+1).

Ports:
- clock  in  1  system clock, all state on posedge.
- resetn  in  1  asynchronous, active-low reset.
- state_enable  in  1  stage enable; low = idle/clear.
- argument  in  ARG_WIDTH  start offset, sampled on the enable rising edge.
- pause  in  1  downstream back-pressure; holds the stream.
- load_we  in  1  buffer write strobe.
- load_addr  in  ADDR_WIDTH  buffer write address.
- load_data  in  CHAR_WIDTH  buffer write data.
- char  out  CHAR_WIDTH  current character.
- char_valid  out  1  `char` is new this cycle.
- has_finished  out  1  stream complete (sticky until disabled).
- char_index  out  ADDR_WIDTH+1  address of the next character to read.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset: `char`=0, `char_valid`=0, `has_finished`=0, `char_index`=0, state=IDLE. Buffer contents are not reset.
- Buffer: DEPTH×CHAR_WIDTH registers with combinational read.
  - Written on posedge when `load_we`=1 and state=IDLE.
  - Writes in any other state are ignored.
- States: IDLE, STREAM, DONE.
- IDLE, while `state_enable`=0:
  - `char`, `char_valid`, `has_finished` are forced to 0 each cycle.
  - On `state_enable`=1: `char_index` ← `argument`.
    - If `argument` ≥ DEPTH: go to DONE, `has_finished`←1 on that edge.
    - Otherwise go to STREAM. No char is emitted on the enable edge.
- STREAM, each posedge:
  - If `pause`=1: `char` holds, `char_valid`←0, index holds.
  - Else if buffer[`char_index`]==0: `has_finished`←1, `char_valid`←0, go to DONE. The NUL is never emitted and `char` keeps the last value.
  - Else: `char`←buffer[`char_index`], `char_valid`←1, `char_index`+1.
    - If `char_index`==DEPTH-1, the next edge enters DONE with `has_finished`←1 (buffer-end termination).
- Latency: first character is valid 2 edges after `state_enable` rises, if `pause` is low. Throughput is 1 char/cycle thereafter.
- DONE: `has_finished`=1, `char_valid`=0, `char` holds. `pause` is ignored.
- `state_enable` falling in any state: next edge returns to IDLE and clears all outputs and `char_index`. This is the mid-stream abort.
- `pause` and terminator in the same cycle: pause wins; the terminator is evaluated on the first unpaused edge.
- `char_index` arithmetic is ADDR_WIDTH+1 bits and never wraps (except under the optional feature).

Optional Feature:
- Macro: `BUFFERED_READER_LOOP_EN`.
- With the macro defined: extra input `loop` (1 bit).
  - In STREAM, when `loop`=1 and a terminator or buffer end is reached, `char_index`← latched start offset instead of entering DONE. `has_finished` stays 0 and streaming continues with no bubble beyond the terminator cycle.
  - `loop`=0 behaves as baseline.
- Without the macro: no `loop` port; termination always enters DONE.

Test Plan:
- Load "<p>hi</p>" at 0..8 and NUL at 9; enable with `argument`=0, `pause`=0. Required: `char_valid` pulses 9 cycles with '<','p','>','h','i','<','/','p','>'. `has_finished`=1 on the edge after '>', and `char` stays '>'.
- Same load, `argument`=3. Required: stream is "hi</p>" (6 chars), then `has_finished`.
- Assert `pause` for 3 cycles after the 2nd char. Required: `char`='p' held, `char_valid`=0 during the pause, `char_index` frozen at 2, and the stream resumes with '>'.
- Fill all 64 entries with 'a' (no NUL). Required: exactly 64 valid chars, then `has_finished`=1. With `argument`=64: `has_finished`=1 with zero chars emitted.
- Drop `state_enable` after 4 chars. Required: next cycle all outputs are 0; re-enable restarts from the new `argument`. Assert `resetn`=0 mid-stream: outputs clear immediately, asynchronously.
- With `BUFFERED_READER_LOOP_EN`, `loop`=1 and "ab"+NUL: required stream is a,b,a,b,… and `has_finished` never rises. Dropping `loop` makes the stream finish at the next NUL.
